// File: rtl/output_unit_if.sv
// Output-port bus: switch-side flit/credit inputs and link-side outputs.
// The switch side (master) drives flits and returned credits; the output unit is the slave.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

interface output_unit_if #(
  parameter int DATA_WIDTH = `ROUTER_WIDTH
);
  logic                  out_unit_en;
  logic [DATA_WIDTH-1:0] st_data_out;
  logic                  credit_in;
  logic                  link_valid;
  logic [DATA_WIDTH-1:0] link_data;
  logic                  credit_avail;
  logic [3:0]            credit_cnt;
  logic                  credit_err;

  modport master (
    output out_unit_en, st_data_out, credit_in,
    input  link_valid, link_data, credit_avail, credit_cnt, credit_err
  );

  modport slave (
    input  out_unit_en, st_data_out, credit_in,
    output link_valid, link_data, credit_avail, credit_cnt, credit_err
  );
endinterface

// File: rtl/output_unit.sv
// Router output unit: one-cycle link register plus downstream credit tracking.
// Optional OUTPUT_UNIT_STATS_EN adds a 32-bit forwarded-flit counter port.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module output_unit #(
  parameter int DATA_WIDTH   = `ROUTER_WIDTH,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  output_unit_if.slave   bus
`ifdef OUTPUT_UNIT_STATS_EN
  ,
  output logic [31:0]    flit_count
`endif
);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CREDIT_DEPTH);

  localparam logic [1:0] IDLE_FULL = 2'd0;
  localparam logic [1:0] PARTIAL   = 2'd1;
  localparam logic [1:0] EMPTY     = 2'd2;

  logic                  link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0] link_data_q,  link_data_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  err_q,        err_d;
  logic [1:0]            cnt_state;
  logic                  snd, rcv, underflow, overflow;

  always_comb begin
    cnt_state = PARTIAL;
    if (cnt_q == '0)          cnt_state = EMPTY;
    else if (cnt_q == DEPTH_C) cnt_state = IDLE_FULL;
  end

  assign snd       = bus.out_unit_en && (cnt_state != EMPTY);
  assign rcv       = bus.credit_in;
  assign underflow = bus.out_unit_en && (cnt_state == EMPTY);
  assign overflow  = rcv && !snd && (cnt_state == IDLE_FULL);

  // A flit sent with no credit still goes out; a credit returned in that
  // same cycle is kept, so the counter lands at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (snd && !rcv)                cnt_d = cnt_q - 1'b1;
    else if (rcv && !snd && !overflow) cnt_d = cnt_q + 1'b1;
    err_d        = err_q | underflow | overflow;
    link_valid_d = bus.out_unit_en;
    link_data_d  = bus.out_unit_en ? bus.st_data_out : link_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      cnt_q        <= DEPTH_C;
      err_q        <= 1'b0;
    end else begin
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.link_valid   = link_valid_q;
  assign bus.link_data    = link_data_q;
  assign bus.credit_cnt   = cnt_q;
  assign bus.credit_avail = (cnt_state != EMPTY);
  assign bus.credit_err   = err_q;

`ifdef OUTPUT_UNIT_STATS_EN
  logic [31:0] fc_q, fc_d;

  always_comb fc_d = fc_q + 32'(link_valid_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fc_q <= '0;
    else        fc_q <= fc_d;
  end

  assign flit_count = fc_q;
`endif
endmodule

// File: tb/tb_output_unit.sv
// Bench for output_unit: directed scenarios with literal expectations, then
// random traffic compared every cycle against a credit-arithmetic model.
module tb_output_unit;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  output_unit_if #(.DATA_WIDTH(DW)) bus ();
`ifdef OUTPUT_UNIT_STATS_EN
  logic [31:0] flit_count;
`endif

  output_unit #(.DATA_WIDTH(DW), .CREDIT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef OUTPUT_UNIT_STATS_EN
    ,
    .flit_count (flit_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: free slots as a plain integer, clipped at the buffer depth.
  int          m_cnt;
  bit          m_err, m_vld;
  logic [DW-1:0] m_data;
  logic [31:0] m_fc;

  function automatic int next_cnt(int c, bit en, bit cr);
    int n;
    n = c - ((en && c > 0) ? 1 : 0) + (cr ? 1 : 0);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic bit violation(int c, bit en, bit cr);
    return (en && c == 0) || (c - ((en && c > 0) ? 1 : 0) + (cr ? 1 : 0) > DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= DEPTH; m_err <= 1'b0; m_vld <= 1'b0; m_data <= '0; m_fc <= '0;
    end else begin
      m_cnt <= next_cnt(m_cnt, bus.out_unit_en, bus.credit_in);
      m_err <= m_err | violation(m_cnt, bus.out_unit_en, bus.credit_in);
      m_vld <= bus.out_unit_en;
      if (bus.out_unit_en) m_data <= bus.st_data_out;
      m_fc  <= m_fc + (bus.out_unit_en ? 32'd1 : 32'd0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.link_valid",   32'(bus.link_valid),   32'(m_vld));
    chk("m.link_data",    bus.link_data,         m_data);
    chk("m.credit_cnt",   32'(bus.credit_cnt),   32'(m_cnt));
    chk("m.credit_avail", 32'(bus.credit_avail), 32'(m_cnt != 0));
    chk("m.credit_err",   32'(bus.credit_err),   32'(m_err));
`ifdef OUTPUT_UNIT_STATS_EN
    chk("m.flit_count",   flit_count,            m_fc);
`endif
  end

  task automatic step(input bit e, input logic [DW-1:0] d, input bit c);
    bus.out_unit_en = e; bus.st_data_out = d; bus.credit_in = c;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_unit_en = 1'b0; bus.st_data_out = '0; bus.credit_in = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.out_unit_en = 1'b1; bus.st_data_out = 32'hDEAD; bus.credit_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.link_valid", 32'(bus.link_valid), 32'd0);
    chk("rst.link_data",  bus.link_data,       32'd0);
    chk("rst.credit_cnt", 32'(bus.credit_cnt), 32'd4);
    bus.out_unit_en = 1'b0; bus.credit_in = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("idle.credit_cnt",   32'(bus.credit_cnt),   32'd4);
    chk("idle.credit_avail", 32'(bus.credit_avail), 32'd1);
    chk("idle.link_valid",   32'(bus.link_valid),   32'd0);
    chk("idle.credit_err",   32'(bus.credit_err),   32'd0);

    for (int i = 0; i < 4; i++) begin
      step(1, 32'hA0 + 32'(i), 0);
      chk("burst.link_data",  bus.link_data,       32'hA0 + 32'(i));
      chk("burst.link_valid", 32'(bus.link_valid), 32'd1);
      chk("burst.credit_cnt", 32'(bus.credit_cnt), 32'(3 - i));
    end
    chk("burst.credit_avail", 32'(bus.credit_avail), 32'd0);

    step(1, 32'h55, 0);
    chk("under.credit_err", 32'(bus.credit_err), 32'd1);
    chk("under.credit_cnt", 32'(bus.credit_cnt), 32'd0);
    chk("under.link_data",  bus.link_data,       32'h55);
    chk("under.link_valid", 32'(bus.link_valid), 32'd1);
    step(0, 0, 0);
    chk("hold.link_data",   bus.link_data,       32'h55);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk("sticky.credit_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("sticky.credit_err", 32'(bus.credit_err), 32'd1);

    do_reset();
    step(0, 0, 0);
    chk("clr.credit_err", 32'(bus.credit_err), 32'd0);
    step(0, 0, 1);
    chk("over.credit_err", 32'(bus.credit_err), 32'd1);
    chk("over.credit_cnt", 32'(bus.credit_cnt), 32'd4);

    do_reset();
    step(1, 32'h1, 0);
    step(1, 32'h2, 0);
    step(1, 32'h3, 1);
    chk("both.credit_cnt", 32'(bus.credit_cnt), 32'd2);
    chk("both.link_valid", 32'(bus.link_valid), 32'd1);
    step(1, 32'h4, 0);
    chk("mid.credit_cnt", 32'(bus.credit_cnt), 32'd1);
    bus.out_unit_en = 1'b1; bus.st_data_out = 32'h5;
    #1 rst_n = 1'b0;
    #1;
    chk("async.link_valid", 32'(bus.link_valid), 32'd0);
    chk("async.credit_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("async.credit_err", 32'(bus.credit_err), 32'd0);
`ifdef OUTPUT_UNIT_STATS_EN
    chk("async.flit_count", flit_count, 32'd0);
`endif
    @(posedge clk); #2;
    bus.out_unit_en = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("post.link_valid", 32'(bus.link_valid), 32'd0);

    do_reset();
    step(1, 32'h10, 0); step(1, 32'h11, 0); step(1, 32'h12, 0); step(1, 32'h13, 0);
    step(1, 32'h14, 1);
    chk("underret.credit_cnt", 32'(bus.credit_cnt), 32'd1);
    chk("underret.credit_err", 32'(bus.credit_err), 32'd1);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_unit.md
OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 Parameter DATA_WIDTH, default `ROUTER_WIDTH, flit width in bits.
REQ-002 Parameter CREDIT_DEPTH, default 4, downstream input-buffer depth in flits; legal range 1..15.
REQ-003 Derived CNT_W = 4 bits; credit counter width, fixed.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 out_unit_en  input  1  switch-traversal valid for this output port.
REQ-007 st_data_out  input  DATA_WIDTH  flit from switch for this port.
REQ-008 credit_in  input  1  one downstream buffer slot freed, per cycle high.
REQ-009 link_valid  output  1  registered flit valid toward downstream router.
REQ-010 link_data  output  DATA_WIDTH  registered flit toward downstream router.
REQ-011 credit_avail  output  1  high when credit_cnt != 0; consumed by switch allocator.
REQ-012 credit_cnt  output  CNT_W  current free downstream slots.
REQ-013 credit_err  output  1  sticky protocol-violation flag.

Function
REQ-014 Link stage: on every clock, link_valid <= out_unit_en and link_data <= st_data_out when out_unit_en=1; link_data holds when out_unit_en=0; latency exactly 1 cycle.
REQ-015 Send event S = out_unit_en & (credit_cnt != 0); receive event R = credit_in.
REQ-016 Counter update: S only -> credit_cnt-1; R only -> credit_cnt+1; S and R same cycle -> unchanged; neither -> unchanged.
REQ-017 Underflow: out_unit_en=1 with credit_cnt=0 -> credit_cnt stays 0, credit_err set, flit still forwarded on link (no drop), link_valid=1.
REQ-018 Overflow: credit_in=1 with credit_cnt=CREDIT_DEPTH and no S -> credit_cnt stays CREDIT_DEPTH, credit_err set.
REQ-019 Simultaneous credit_in and out_unit_en at credit_cnt=0 -> counts as underflow per REQ-017, and credit_cnt becomes 1 (returned credit kept).
REQ-020 credit_err sticky; cleared only by reset.
REQ-021 credit_avail is combinational from registered credit_cnt; no dependence on same-cycle inputs.
REQ-022 State encoding of counter: IDLE_FULL (cnt=CREDIT_DEPTH), PARTIAL, EMPTY (cnt=0); credit_avail=0 only in EMPTY.

Reset
REQ-023 rst_n low asynchronously forces link_valid=0, link_data=0, credit_cnt=CREDIT_DEPTH, credit_err=0.
REQ-024 Reset mid-transfer discards any in-flight flit; first cycle after release link_valid=0 regardless of out_unit_en sampled during reset.
REQ-025 Inputs ignored while rst_n low; first update at first rising edge with rst_n high.

Configuration
REQ-026 Macro OUTPUT_UNIT_STATS_EN defined: adds output flit_count, 32 bits, reset 0, incremented on every cycle link_valid is registered high, wraps 0xFFFFFFFF -> 0.
REQ-027 OUTPUT_UNIT_STATS_EN undefined: port flit_count and its counter absent; all other behaviour identical.

Verification
REQ-028 Reset release, no traffic -> credit_cnt=4, credit_avail=1, link_valid=0, credit_err=0.
REQ-029 Four consecutive out_unit_en with data 0xA0..0xA3, no credit_in -> link_data 0xA0..0xA3 each one cycle later, credit_cnt 3,2,1,0, credit_avail=0 after fourth.
REQ-030 At credit_cnt=2, out_unit_en=1 and credit_in=1 same cycle -> credit_cnt stays 2, link_valid=1 next cycle.
REQ-031 At credit_cnt=0, out_unit_en=1 -> credit_err=1, credit_cnt=0, flit on link; credit_err remains 1 after ten more credit_in pulses restoring cnt to 4.
REQ-032 At credit_cnt=4, credit_in=1 -> credit_err=1, credit_cnt=4.
REQ-033 rst_n pulsed low mid-burst at credit_cnt=1 -> immediate link_valid=0, credit_cnt=4, credit_err=0; with OUTPUT_UNIT_STATS_EN, flit_count=0.
